// File: rtl/bcd_pkg.sv
// bcd_pkg -- shared types, constants and helpers for the BCD wrap counter.
// The digit type is one packed BCD nibble. bcd_valid() checks that a packed
// BCD word holds only decimal nibbles. It is used both for the LIMIT
// parameter and for runtime load values.
package bcd_pkg;

   // One BCD digit (legal codes 0..9)
   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_NINE = 4'd9;
   localparam bcd_digit_t BCD_ZERO = 4'd0;

   // Largest supported digit count; the helper works on a 32-bit container
   localparam int BCD_MAX_DIGITS = 8;

   // True when every one of the low ndig nibbles of v is a decimal digit.
   // Nibbles above ndig are not examined.
   function automatic logic bcd_valid(input logic [31:0] v, input int ndig);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
         if ((i < ndig) && (v[4*i +: 4] > BCD_NINE)) begin
            ok = 1'b0;
         end
      end
      return ok;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit -- combinational next-state for one BCD digit of a ripple chain.
// carry_in doubles as borrow_in and carry_out as borrow_out. The inc/dec
// inputs select which of the two the chain is doing. Digit 0 of the chain
// has carry_in tied high, so that a step always reaches it.
module bcd_digit
   import bcd_pkg::*;
(
   input  bcd_digit_t digit_in,
   input  logic       inc,
   input  logic       dec,
   input  logic       carry_in,
   output bcd_digit_t digit_next,
   output logic       carry_out
);

   // Roll 9->0 with carry when counting up, 0->9 with borrow when counting down
   always_comb begin
      digit_next = digit_in;
      carry_out  = 1'b0;
      if (carry_in) begin
         if (inc) begin
            if (digit_in >= BCD_NINE) begin
               digit_next = BCD_ZERO;
               carry_out  = 1'b1;
            end else begin
               digit_next = digit_in + 4'd1;
            end
         end else if (dec) begin
            if (digit_in == BCD_ZERO) begin
               digit_next = BCD_NINE;
               carry_out  = 1'b1;
            end else begin
               digit_next = digit_in - 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/bcd_wrap_counter.sv
// bcd_wrap_counter -- multi-digit BCD counter that wraps at LIMIT.
// It steps once per qualified tick: count_enable & start_stop_reg & ~load.
// A load takes priority over a step. A load is rejected when load_value is
// not valid BCD or is above LIMIT; a rejected load raises a one-cycle
// load_err pulse. The wrap output pulses for one cycle on a terminal wrap.
// The reset input is asynchronous and active low.
// Optional feature macro: BCD_DOWN_EN. When it is defined, the block has the
// up_down port and can count down. A down step from zero wraps to LIMIT.
// Without the macro, the block counts up only.
module bcd_wrap_counter
   import bcd_pkg::*;
#(
   parameter int                      NUM_DIGITS = 2,
   parameter logic [4*NUM_DIGITS-1:0] LIMIT      = 'h59
)
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      count_enable,
   input  logic                      start_stop_reg,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   load_value,
`ifdef BCD_DOWN_EN
   input  logic                      up_down,
`endif
   output logic [4*NUM_DIGITS-1:0]   value,
   output logic                      wrap,
   output logic                      load_err
);

   localparam int W = 4 * NUM_DIGITS;

   // A malformed LIMIT would let the counter reach non-BCD codes through
   // loads, so every load is refused in that case.
   localparam logic LIMIT_VALID = bcd_valid(32'(LIMIT), NUM_DIGITS);

   logic [W-1:0] value_q, value_d;
   logic         wrap_q, wrap_d;
   logic         load_err_q, load_err_d;

   logic         step_en;
   logic         count_up;
   logic         at_limit;
   logic         load_ok;
   logic [W-1:0] chain_value;
   logic [NUM_DIGITS:0] chain_carry;

`ifdef BCD_DOWN_EN
   assign count_up = up_down;
`else
   assign count_up = 1'b1;
`endif

   assign step_en  = count_enable & start_stop_reg & ~load;
   assign at_limit = (value_q == LIMIT);

   // All nibbles are decimal, so a plain binary compare orders the values numerically
   assign load_ok  = LIMIT_VALID
                   & bcd_valid(32'(load_value), NUM_DIGITS)
                   & (load_value <= LIMIT);

   // Ripple chain of digit cells. Digit 0 always sees an active carry/borrow.
   assign chain_carry[0] = 1'b1;

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         bcd_digit u_digit (
            .digit_in   (value_q[4*gi +: 4]),
            .inc        (count_up),
            .dec        (~count_up),
            .carry_in   (chain_carry[gi]),
            .digit_next (chain_value[4*gi +: 4]),
            .carry_out  (chain_carry[gi+1])
         );
      end
   endgenerate

   // Next-state selection: the load has priority, then a step. A step that
   // reaches the terminal count wraps.
   always_comb begin
      value_d    = value_q;
      wrap_d     = 1'b0;
      load_err_d = 1'b0;
      if (load) begin
         if (load_ok) begin
            value_d = load_value;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (step_en) begin
         if (count_up) begin
            // A carry out of the top digit means the value was all nines.
            // That can only be LIMIT.
            if (at_limit || chain_carry[NUM_DIGITS]) begin
               value_d = '0;
               wrap_d  = 1'b1;
            end else begin
               value_d = chain_value;
            end
         end
`ifdef BCD_DOWN_EN
         else begin
            // A borrow out of the top digit happens exactly when the value was zero
            if (chain_carry[NUM_DIGITS]) begin
               value_d = LIMIT;
               wrap_d  = 1'b1;
            end else begin
               value_d = chain_value;
            end
         end
`endif
      end
   end

   // State and output registers. The asynchronous reset discards any operation in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         value_q    <= '0;
         wrap_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         value_q    <= value_d;
         wrap_q     <= wrap_d;
         load_err_q <= load_err_d;
      end
   end

   assign value    = value_q;
   assign wrap     = wrap_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_wrap_counter.sv
// tb_bcd_wrap_counter -- self-checking bench for bcd_wrap_counter.
// Two instances share the control inputs: the default 2-digit/59 build, and a
// 4-digit build with LIMIT 2359. The reference model holds plain integers and
// applies the counter rules arithmetically. Directed cases are followed by
// randomized traffic. Define BCD_DOWN_EN to include the down-count cases.
module tb_bcd_wrap_counter;

   logic        clk = 1'b0;
   logic        reset;
   logic        count_enable;
   logic        start_stop_reg;
   logic        load;
   logic        up_down;
   logic [7:0]  load_value2;
   logic [15:0] load_value4;
   logic [7:0]  value2;
   logic [15:0] value4;
   logic        wrap2, load_err2, wrap4, load_err4;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model state (plain decimal integers) and expected pulses
   int   m2, m4;
   logic ew2, ee2, ew4, ee4;

   always #5 clk = ~clk;

   bcd_wrap_counter u_dut2 (
      .clk            (clk),
      .reset          (reset),
      .count_enable   (count_enable),
      .start_stop_reg (start_stop_reg),
      .load           (load),
      .load_value     (load_value2),
`ifdef BCD_DOWN_EN
      .up_down        (up_down),
`endif
      .value          (value2),
      .wrap           (wrap2),
      .load_err       (load_err2)
   );

   bcd_wrap_counter #(.NUM_DIGITS(4), .LIMIT(16'h2359)) u_dut4 (
      .clk            (clk),
      .reset          (reset),
      .count_enable   (count_enable),
      .start_stop_reg (start_stop_reg),
      .load           (load),
      .load_value     (load_value4),
`ifdef BCD_DOWN_EN
      .up_down        (up_down),
`endif
      .value          (value4),
      .wrap           (wrap4),
      .load_err       (load_err4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] int2bcd(input int x);
      logic [31:0] r;
      int t;
      r = '0;
      t = x;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic int bcd2int(input logic [31:0] v, input int nd);
      int acc;
      acc = 0;
      for (int i = nd - 1; i >= 0; i--) acc = acc * 10 + int'(v[4*i +: 4]);
      return acc;
   endfunction

   function automatic logic bcd_ok(input logic [31:0] v, input int nd);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < nd; i++) if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      return ok;
   endfunction

   // Applies the counter rules to one model, using the inputs present at the edge
   task automatic model_step(inout int m, input int lim, input int nd,
                             input logic [31:0] lv, output logic w, output logic e);
      w = 1'b0;
      e = 1'b0;
      if (load) begin
         if (bcd_ok(lv, nd) && (bcd2int(lv, nd) <= lim)) m = bcd2int(lv, nd);
         else e = 1'b1;
      end else if (count_enable && start_stop_reg) begin
         if (up_down) begin
            if (m == lim) begin m = 0; w = 1'b1; end
            else m = m + 1;
         end else begin
            if (m == 0) begin m = lim; w = 1'b1; end
            else m = m - 1;
         end
      end
   endtask

   task automatic drive(input logic ce, input logic run, input logic ld,
                        input logic [7:0] lv2, input logic [15:0] lv4);
      count_enable   = ce;
      start_stop_reg = run;
      load           = ld;
      load_value2    = lv2;
      load_value4    = lv4;
   endtask

   // One clock: advance the model at the edge, then compare all outputs 1 time unit later
   task automatic cycle();
      @(posedge clk);
      model_step(m2, 59, 2, 32'(load_value2), ew2, ee2);
      model_step(m4, 2359, 4, 32'(load_value4), ew4, ee4);
      #1;
      check("value2", 32'(value2), int2bcd(m2));
      check("wrap2", 32'(wrap2), 32'(ew2));
      check("load_err2", 32'(load_err2), 32'(ee2));
      check("value4", 32'(value4), int2bcd(m4));
      check("wrap4", 32'(wrap4), 32'(ew4));
      check("load_err4", 32'(load_err4), 32'(ee4));
      $display("[TB] t=%0t ce=%0b run=%0b ld=%0b ud=%0b lv=%h/%h -> v2=%h w2=%0b e2=%0b v4=%h w4=%0b e4=%0b",
               $time, count_enable, start_stop_reg, load, up_down, load_value2, load_value4,
               value2, wrap2, load_err2, value4, wrap4, load_err4);
   endtask

   int          nwraps;
   int          wrap_idx;
   logic [7:0]  held2;
   logic [15:0] held4;

   initial begin
      reset = 1'b0;
      up_down = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
      m2 = 0;
      m4 = 0;

      // The asynchronous reset forces zero before any clock edge
      #2;
      check("rst_value2", 32'(value2), 32'h0);
      check("rst_wrap2", 32'(wrap2), 32'h0);
      check("rst_err2", 32'(load_err2), 32'h0);
      check("rst_value4", 32'(value4), 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Default build: 60 ticks go 00..59 and then back to 00, with a single wrap
      drive(1'b1, 1'b1, 1'b0, 8'h00, 16'h0000);
      nwraps = 0;
      wrap_idx = 0;
      for (int i = 1; i <= 60; i++) begin
         cycle();
         if (wrap2) begin
            nwraps++;
            wrap_idx = i;
         end
         if (i == 59) check("req32_at59", 32'(value2), 32'h59);
      end
      check("req32_final", 32'(value2), 32'h00);
      check("req32_wraps", 32'(nwraps), 32'd1);
      check("req32_wrap_tick", 32'(wrap_idx), 32'd60);

      // Four-digit carry across three digits, then the terminal wrap at 2359
      drive(1'b0, 1'b1, 1'b1, 8'h12, 16'h0999);
      cycle();
      drive(1'b1, 1'b1, 1'b0, 8'h00, 16'h0000);
      cycle();
      check("req33_carry", 32'(value4), 32'h1000);
      check("req33_nowrap", 32'(wrap4), 32'h0);
      drive(1'b0, 1'b1, 1'b1, 8'h12, 16'h2359);
      cycle();
      drive(1'b1, 1'b1, 1'b0, 8'h00, 16'h0000);
      cycle();
      check("req33_wrapval", 32'(value4), 32'h0000);
      check("req33_wrap", 32'(wrap4), 32'h1);
      drive(1'b0, 1'b1, 1'b0, 8'h00, 16'h0000);
      cycle();
      check("req33_wrap_once", 32'(wrap4), 32'h0);

      // Rejected loads and load priority over a tick
      drive(1'b0, 1'b1, 1'b1, 8'h34, 16'h1234);
      cycle();
      drive(1'b0, 1'b1, 1'b1, 8'h5A, 16'h12A4);
      cycle();
      check("req34_5A_err", 32'(load_err2), 32'h1);
      check("req34_5A_hold", 32'(value2), 32'h34);
      check("req34_4dig_err", 32'(load_err4), 32'h1);
      drive(1'b0, 1'b1, 1'b1, 8'h60, 16'h2400);
      cycle();
      check("req34_60_err", 32'(load_err2), 32'h1);
      check("req34_60_hold", 32'(value2), 32'h34);
      drive(1'b0, 1'b1, 1'b0, 8'h00, 16'h0000);
      cycle();
      check("req34_err_once", 32'(load_err2), 32'h0);
      drive(1'b1, 1'b1, 1'b1, 8'h21, 16'h0555);
      cycle();
      check("req34_ld_wins", 32'(value2), 32'h21);

      // run=0 holds the value across ticks; a load still acts
      drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
      held2 = value2;
      held4 = value4;
      for (int i = 0; i < 10; i++) cycle();
      check("req36_hold2", 32'(value2), 32'(held2));
      check("req36_hold4", 32'(value4), 32'(held4));
      drive(1'b1, 1'b0, 1'b1, 8'h45, 16'h1845);
      cycle();
      check("req36_ld_stopped", 32'(value2), 32'h45);

      // Reset pulsed between edges while counting
      drive(1'b1, 1'b1, 1'b0, 8'h00, 16'h0000);
      cycle();
      cycle();
      #3;
      reset = 1'b0;
      #1;
      check("req36_async_v2", 32'(value2), 32'h0);
      check("req36_async_v4", 32'(value4), 32'h0);
      m2 = 0;
      m4 = 0;
      #1;
      reset = 1'b1;
      cycle();
      check("req26_first_step", 32'(value2), 32'h01);

      // A reset held across an edge discards a pending load
      drive(1'b0, 1'b1, 1'b1, 8'h33, 16'h0033);
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("req25_ld_discard", 32'(value2), 32'h0);
      check("req25_ld_discard_err", 32'(load_err2), 32'h0);
      m2 = 0;
      m4 = 0;
      @(negedge clk);
      reset = 1'b1;
      drive(1'b0, 1'b1, 1'b0, 8'h00, 16'h0000);

`ifdef BCD_DOWN_EN
      // Down counting, with a borrow across a digit and the wrap from zero to LIMIT
      up_down = 1'b0;
      drive(1'b0, 1'b1, 1'b1, 8'h10, 16'h0010);
      cycle();
      drive(1'b1, 1'b1, 1'b0, 8'h00, 16'h0000);
      cycle();
      check("req35_09", 32'(value2), 32'h09);
      cycle();
      check("req35_08", 32'(value2), 32'h08);
      drive(1'b0, 1'b1, 1'b1, 8'h00, 16'h0000);
      cycle();
      drive(1'b1, 1'b1, 1'b0, 8'h00, 16'h0000);
      cycle();
      check("req35_wrap_val", 32'(value2), 32'h59);
      check("req35_wrap", 32'(wrap2), 32'h1);
      check("req35_wrap4_val", 32'(value4), 32'h2359);
      up_down = 1'b1;
`endif

      // Randomized traffic. Loads are mostly legal values, with some arbitrary
      // bit patterns mixed in.
      for (int i = 0; i < 400; i++) begin
         count_enable   = 1'($urandom_range(0, 1));
         start_stop_reg = ($urandom_range(0, 7) != 0);
         load           = ($urandom_range(0, 9) == 0);
`ifdef BCD_DOWN_EN
         up_down        = 1'($urandom_range(0, 1));
`endif
         if ($urandom_range(0, 1) == 1) begin
            load_value2 = 8'(int2bcd($urandom_range(0, 59)));
            load_value4 = 16'(int2bcd($urandom_range(0, 2359)));
         end else begin
            load_value2 = 8'($urandom);
            load_value4 = 16'($urandom);
         end
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/bcd_wrap_counter.md
BCD_WRAP_COUNTER -- requirements
Module: bcd_wrap_counter

Interface
REQ-001 Parameter NUM_DIGITS, default 2, SHALL set the number of BCD digits (range 1..8).
REQ-002 Parameter LIMIT, default BCD 'h59 (4*NUM_DIGITS bits), SHALL set the terminal count; every nibble SHALL be 0..9.
REQ-003 clk  input  1  single clock for all state.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 count_enable  input  1  one-cycle tick strobe from the frequency divider; one strobe allows at most one step.
REQ-006 start_stop_reg  input  1  run level: 1 = counting allowed, 0 = hold.
REQ-007 load  input  1  synchronous load request.
REQ-008 load_value  input  4*NUM_DIGITS  BCD value to load, digit 0 in bits [3:0].
REQ-009 up_down  input  1  1 = count up, 0 = count down; present only with BCD_DOWN_EN.
REQ-010 value  output  4*NUM_DIGITS  registered BCD count, digit 0 = least significant.
REQ-011 wrap  output  1  registered one-cycle pulse on terminal wrap.
REQ-012 load_err  output  1  registered one-cycle pulse on a rejected load.

Function
REQ-013 A step SHALL occur on a rising clk edge when count_enable=1, start_stop_reg=1 and load=0; value SHALL update on that same edge, giving 1-cycle latency.
REQ-014 An up step SHALL increment digit 0; a digit at 9 SHALL become 0 and carry into the next digit.
REQ-015 An up step from value==LIMIT SHALL set value to all-zero and assert wrap for exactly one cycle.
REQ-016 A down step SHALL decrement digit 0; a digit at 0 SHALL become 9 and borrow from the next digit.
REQ-017 A down step from all-zero SHALL set value to LIMIT and assert wrap for exactly one cycle.
REQ-018 load=1 SHALL take priority over a step in the same cycle.
REQ-019 A load whose load_value has every nibble <=9 and is <=LIMIT SHALL set value=load_value on the next edge.
REQ-020 Any other load SHALL leave value unchanged and pulse load_err for one cycle.
REQ-021 When start_stop_reg=0, value SHALL hold, count_enable SHALL be ignored, and load SHALL still act.
REQ-022 wrap and load_err SHALL be 0 in every cycle not named in REQ-015, REQ-017 and REQ-020.
REQ-023 value SHALL never hold a nibble >9 or a value >LIMIT.

Reset
REQ-024 reset=0 SHALL immediately force value=0, wrap=0 and load_err=0, independent of clk.
REQ-025 A reset asserted mid-count or during a load SHALL discard that operation.
REQ-026 The first step SHALL be the first qualifying edge after reset deasserts.

Configuration
REQ-027 With macro BCD_DOWN_EN defined, the up_down port and the borrow/down-wrap logic SHALL be present.
REQ-028 Without BCD_DOWN_EN, the up_down port SHALL be absent and the block SHALL count up only.

Structure
REQ-029 Package bcd_pkg SHALL hold the digit type (4-bit), the constants BCD_NINE and BCD_ZERO, and the LIMIT validity-check function.
REQ-030 One sub-module, bcd_digit, SHALL implement a single digit; inputs: inc, dec, carry/borrow in; outputs: next digit, carry/borrow out.
REQ-031 The top level SHALL instantiate NUM_DIGITS bcd_digit cells plus the limit compare, load check and output registers.

Verification
REQ-032 Defaults: reset, run=1, 60 ticks -> value steps 00..59 then 00; wrap high exactly once, on the 60th tick.
REQ-033 NUM_DIGITS=4, LIMIT='h2359: load 'h0999, one tick -> value 'h1000 with no wrap; load 'h2359, one tick -> 'h0000 with wrap=1.
REQ-034 Load 'h5A -> load_err pulse and value unchanged; load 'h60 with LIMIT 'h59 -> load_err pulse; load together with a tick -> loaded value wins.
REQ-035 With BCD_DOWN_EN, up_down=0, value 'h10, two ticks -> 'h09 then 'h08; from 'h00, one tick -> 'h59 with wrap=1.
REQ-036 run=0 with 10 ticks -> value constant; reset pulsed between clk edges mid-count -> value=0 before the next edge.
